// File: rtl/axi_slave_mem.sv
// AXI4 slave with a DEPTH-word memory that clears on reset; one transaction in flight.
// Define AXI_SLAVE_MEM_WRAP_EN to support WRAP bursts; otherwise every WRAP beat answers SLVERR.
module axi_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned NB_LOG = $clog2(NB);
  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AXI_SLAVE_MEM_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWdata, StWresp, StRdata} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic [1:0]            burst_q, burst_d;
  logic                  burst_err_q, burst_err_d;
  logic                  err_seen_q, err_seen_d;
  logic                  grant_rd_q, grant_rd_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  beat_err, last_beat, mem_we;

  // Burst-wide errors are decided once at the address handshake.
  function automatic logic calc_burst_err(input logic [NB_LOG-1:0] lsb, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic err;
    err = (size != 3'(NB_LOG)) || (burst == 2'b11);
    if (burst == 2'b10) begin
      err = err || !WrapEn || (lsb != '0) ||
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    end
    return err;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] cur,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] inc, mask;
    inc  = cur + ADDR_WIDTH'(NB);
    mask = ADDR_WIDTH'((32'(len) + 32'd1) * NB - 32'd1);
    case (burst)
      2'b00:   return cur;
      2'b10:   return (cur & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  assign word_idx  = addr_q >> NB_LOG;
  assign beat_err  = burst_err_q || !(32'(word_idx) < DEPTH);
  assign last_beat = (cnt_q == len_q);

  assign awready = areset_n && (state_q == StIdle);
  assign arready = areset_n && (state_q == StIdle);
  assign wready  = (state_q == StWdata);
  assign bvalid  = (state_q == StWresp);
  assign bresp   = (bvalid && err_seen_q) ? 2'b10 : 2'b00;
  assign rvalid  = (state_q == StRdata);
  assign rlast   = rvalid && last_beat;
  assign rresp   = (rvalid && beat_err) ? 2'b10 : 2'b00;
  assign rdata   = (rvalid && !beat_err) ? mem_q[word_idx[IW-1:0]] : '0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    burst_err_d = burst_err_q;
    err_seen_d  = err_seen_q;
    grant_rd_d  = grant_rd_q;
    mem_we      = 1'b0;
    case (state_q)
      StIdle: begin
        if (awvalid && arvalid) grant_rd_d = ~grant_rd_q;
        if (awvalid && !(arvalid && grant_rd_q)) begin
          addr_d      = awaddr;
          len_d       = awlen;
          burst_d     = awburst;
          burst_err_d = calc_burst_err(awaddr[NB_LOG-1:0], awlen, awsize, awburst);
          cnt_d       = '0;
          err_seen_d  = 1'b0;
          state_d     = StWdata;
        end else if (arvalid) begin
          addr_d      = araddr;
          len_d       = arlen;
          burst_d     = arburst;
          burst_err_d = calc_burst_err(araddr[NB_LOG-1:0], arlen, arsize, arburst);
          cnt_d       = '0;
          state_d     = StRdata;
        end
      end
      StWdata: begin
        if (wvalid) begin
          mem_we     = !beat_err;
          err_seen_d = err_seen_q || beat_err || (wlast != last_beat);
          addr_d     = next_addr(addr_q, len_q, burst_q);
          cnt_d      = cnt_q + 8'd1;
          if (last_beat) state_d = StWresp;
        end
      end
      StWresp: begin
        if (bready) state_d = StIdle;
      end
      StRdata: begin
        if (rready) begin
          addr_d = next_addr(addr_q, len_q, burst_q);
          cnt_d  = cnt_q + 8'd1;
          if (last_beat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
      err_seen_q  <= 1'b0;
      grant_rd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
      err_seen_q  <= err_seen_d;
      grant_rd_q  <= grant_rd_d;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb[b]) mem_q[word_idx[IW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed vector table, hand-written corner sequences
// and randomized bursts checked against a byte-level memory model.
module tb_axi_slave_mem;
  localparam int unsigned AW = 16, DW = 32, NB = 4, DEPTH = 256;
`ifdef AXI_SLAVE_MEM_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic          aclk = 1'b0, areset_n = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          awready, wready, bvalid, arready, rlast, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  always #5 aclk = ~aclk;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_tests = 0, n_fail = 0;
  logic [31:0] mdl [DEPTH];

  typedef struct {
    bit          wr;
    int          addr, len, size, burst;
    logic [3:0]  strb;
    logic [31:0] d0;
    logic [1:0]  exp_resp;   // bresp, or rresp of the first read beat
    logic [31:0] exp_first, exp_last;
    int          exp_nerr;
  } vec_t;

  function automatic vec_t mk(bit wr, int addr, int len, int size, int burst, logic [3:0] strb,
                              logic [31:0] d0, logic [1:0] er, logic [31:0] ef,
                              logic [31:0] el, int en);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.strb = strb;
    v.d0 = d0; v.exp_resp = er; v.exp_first = ef; v.exp_last = el; v.exp_nerr = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within 50 cycles, required one", name);
  endtask

  // Reference model: addresses and errors straight from the burst rules.
  function automatic bit m_burst_err(int addr, int len, int size, int burst);
    if (size != 2 || burst == 3) return 1'b1;
    if (burst == 2)
      return !WrapEn || !(len == 1 || len == 3 || len == 7 || len == 15) || (addr % NB != 0);
    return 1'b0;
  endfunction

  function automatic int m_addr(int start, int len, int burst, int i);
    int blk, base;
    if (burst == 0) return start;
    if (burst == 2) begin
      blk  = (len + 1) * NB;
      base = start - (start % blk);
      return base + ((start - base + i * NB) % blk);
    end
    return (start + i * NB) % 65536;
  endfunction

  function automatic bit m_beat_ok(int addr, int len, int size, int burst, int i);
    return !m_burst_err(addr, len, size, burst) && (m_addr(addr, len, burst, i) / NB < DEPTH);
  endfunction

  task automatic do_reset();
    awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
    areset_n = 1'b0;
    #1;
    check("rst awready", awready, 0); check("rst arready", arready, 0);
    check("rst wready", wready, 0);   check("rst bvalid", bvalid, 0);
    check("rst rvalid", rvalid, 0);   check("rst bresp", bresp, 0);
    check("rst rresp", rresp, 0);     check("rst rdata", rdata, 0);
    check("rst rlast", rlast, 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    repeat (2) @(posedge aclk);
    #3 areset_n = 1'b1;
    #1;
    check("post-rst awready", awready, 1); check("post-rst arready", arready, 1);
  endtask

  task automatic do_write(input int addr, input int len, input int size, input int burst,
                          input logic [3:0] strb, input logic [31:0] d0, input bit bad_wlast,
                          input bit rnd, output logic [1:0] resp);
    int to, idx;
    bit exp_err;
    logic [31:0] wd;
    awaddr = AW'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1;
    to = 0;
    while (!awready && to < 50) begin @(posedge aclk); #1; to++; end
    if (to >= 50) note_timeout("awready");
    @(posedge aclk); #1; awvalid = 0;
    exp_err = bad_wlast;
    for (int i = 0; i <= len; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      wd = d0 + 32'(i);
      wdata = wd; wstrb = strb; wlast = bad_wlast ? (i != len) : (i == len); wvalid = 1;
      to = 0;
      while (!wready && to < 50) begin @(posedge aclk); #1; to++; end
      if (to >= 50) note_timeout("wready");
      @(posedge aclk); #1; wvalid = 0; wlast = 0;
      if (m_beat_ok(addr, len, size, burst, i)) begin
        idx = m_addr(addr, len, burst, i) / NB;
        for (int k = 0; k < NB; k++) if (strb[k]) mdl[idx][8*k +: 8] = wd[8*k +: 8];
      end else begin
        exp_err = 1'b1;
      end
    end
    to = 0;
    while (!bvalid && to < 50) begin @(posedge aclk); #1; to++; end
    if (to >= 50) note_timeout("bvalid");
    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    resp = bresp;
    check("bresp model", bresp, exp_err ? 2'b10 : 2'b00);
    bready = 1; @(posedge aclk); #1; bready = 0;
  endtask

  task automatic do_read(input int addr, input int len, input int size, input int burst,
                         input bit rnd, output logic [31:0] d_first, output logic [31:0] d_last,
                         output int nerr, output logic [1:0] resp0);
    int to, stall;
    bit ok;
    logic [31:0] exp_d;
    araddr = AW'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1;
    to = 0;
    while (!arready && to < 50) begin @(posedge aclk); #1; to++; end
    if (to >= 50) note_timeout("arready");
    @(posedge aclk); #1; arvalid = 0;
    nerr = 0; d_first = '0; d_last = '0; resp0 = '0;
    for (int i = 0; i <= len; i++) begin
      ok    = m_beat_ok(addr, len, size, burst, i);
      exp_d = ok ? mdl[m_addr(addr, len, burst, i) / NB] : 32'h0;
      to = 0;
      while (!rvalid && to < 50) begin @(posedge aclk); #1; to++; end
      if (to >= 50) note_timeout("rvalid");
      stall = rnd ? int'($urandom_range(0, 2)) : 0;
      repeat (stall) begin check("rdata held", rdata, exp_d); @(posedge aclk); #1; end
      check($sformatf("rdata beat %0d", i), rdata, exp_d);
      check($sformatf("rresp beat %0d", i), rresp, ok ? 2'b00 : 2'b10);
      check($sformatf("rlast beat %0d", i), rlast, (i == len));
      if (i == 0) begin d_first = rdata; resp0 = rresp; end
      if (i == len) d_last = rdata;
      if (rresp == 2'b10) nerr++;
      rready = 1; @(posedge aclk); #1; rready = 0;
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [1:0]  resp, r0;
    logic [31:0] df, dl;
    int          ne, to;
    int          wl[4] = '{1, 3, 7, 15};

    vecs.push_back(mk(1, 'h10, 3, 2, 1, 4'hF, 32'hA0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 'h10, 3, 2, 1, 4'h0, 0, 2'b00, 32'hA0, 32'hA3, 0));
    vecs.push_back(mk(1, 'h0, 0, 2, 1, 4'hF, 32'hFFFFFFFF, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 'h0, 0, 2, 1, 4'h5, 32'h11223344, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 'h0, 0, 2, 1, 4'h0, 0, 2'b00, 32'hFF22FF44, 32'hFF22FF44, 0));
    vecs.push_back(mk(1, 'h3F8, 1, 2, 1, 4'hF, 32'h50000000, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 'h3F8, 3, 2, 1, 4'h0, 0, 2'b00, 32'h50000000, 32'h0, 2));
    vecs.push_back(mk(1, 'h18, 3, 2, 2, 4'hF, 32'hC0, WrapEn ? 2'b00 : 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 'h10, 3, 2, 1, 4'h0, 0, 2'b00, WrapEn ? 32'hC2 : 32'hA0,
                      WrapEn ? 32'hC1 : 32'hA3, 0));
    vecs.push_back(mk(0, 'h18, 3, 2, 2, 4'h0, 0, WrapEn ? 2'b00 : 2'b10,
                      WrapEn ? 32'hC0 : 32'h0, WrapEn ? 32'hC3 : 32'h0, WrapEn ? 0 : 4));
    vecs.push_back(mk(1, 'h20, 0, 1, 1, 4'hF, 32'h99, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 'h20, 0, 2, 1, 4'h0, 0, 2'b00, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 'h24, 1, 2, 3, 4'hF, 32'h77, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 'h10, 2, 2, 0, 4'h0, 0, 2'b00, WrapEn ? 32'hC2 : 32'hA0,
                      WrapEn ? 32'hC2 : 32'hA0, 0));
    vecs.push_back(mk(1, 'h3FC, 1, 2, 1, 4'hF, 32'hDD, 2'b10, 0, 0, 0));
    vecs.push_back(mk(0, 'h3FC, 0, 2, 1, 4'h0, 0, 2'b00, 32'hDD, 32'hDD, 0));
    vecs.push_back(mk(1, 'h0, 255, 2, 1, 4'hF, 32'h1000, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 'h3FC, 0, 2, 1, 4'h0, 0, 2'b00, 32'h10FF, 32'h10FF, 0));

    #2;
    do_reset();

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].strb,
                 vecs[i].d0, 1'b0, 1'b0, resp);
        check($sformatf("vec%0d bresp", i), resp, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 1'b0, df, dl, ne, r0);
        check($sformatf("vec%0d first", i), df, vecs[i].exp_first);
        check($sformatf("vec%0d last", i), dl, vecs[i].exp_last);
        check($sformatf("vec%0d nerr", i), ne, vecs[i].exp_nerr);
        check($sformatf("vec%0d resp0", i), r0, vecs[i].exp_resp);
      end
    end

    // wlast on the wrong beat: data lands but the response is SLVERR
    do_write('h30, 1, 2, 1, 4'hF, 32'hE0, 1'b1, 1'b0, resp);
    check("bad wlast bresp", resp, 2'b10);
    do_read('h30, 1, 2, 1, 1'b0, df, dl, ne, r0);
    check("bad wlast data", dl, 32'hE1);

    // Two collisions in a row after reset: write wins, then read; read held with rready low.
    do_reset();
    @(posedge aclk); #1;
    awaddr = 16'h80; awlen = 0; awsize = 2; awburst = 1; awvalid = 1;
    araddr = 16'h80; arlen = 0; arsize = 2; arburst = 1; arvalid = 1;
    @(posedge aclk); #1; awvalid = 0;
    check("coll1 wready", wready, 1);
    check("coll1 rvalid", rvalid, 0);
    wdata = 32'h5A5A1234; wstrb = 4'hF; wlast = 1; wvalid = 1;
    @(posedge aclk); #1; wvalid = 0; wlast = 0;
    mdl[32] = 32'h5A5A1234;
    check("coll1 bvalid", bvalid, 1);
    check("coll1 bresp", bresp, 2'b00);
    bready = 1; @(posedge aclk); #1; bready = 0;
    awvalid = 1;
    @(posedge aclk); #1; awvalid = 0; arvalid = 0;
    check("coll2 rvalid", rvalid, 1);
    check("coll2 wready", wready, 0);
    for (int k = 0; k < 3; k++) begin
      check("coll2 rdata stall", rdata, mdl[32]);
      @(posedge aclk); #1;
    end
    check("coll2 rdata", rdata, 32'h5A5A1234);
    check("coll2 rlast", rlast, 1);
    check("coll2 rresp", rresp, 2'b00);
    rready = 1; @(posedge aclk); #1; rready = 0;
    check("coll2 back idle", awready, 1);

    // Reset during beat 2 of a len-7 read.
    do_write('h40, 7, 2, 1, 4'hF, 32'h70000000, 1'b0, 1'b0, resp);
    araddr = 16'h40; arlen = 7; arsize = 2; arburst = 1; arvalid = 1;
    to = 0;
    while (!arready && to < 50) begin @(posedge aclk); #1; to++; end
    if (to >= 50) note_timeout("arready mid-reset");
    @(posedge aclk); #1; arvalid = 0;
    check("midrst beat1", rdata, 32'h70000000);
    rready = 1; @(posedge aclk); #1; rready = 0;
    check("midrst beat2 valid", rvalid, 1);
    check("midrst beat2 data", rdata, 32'h70000001);
    do_reset();
    do_read('h40, 7, 2, 1, 1'b0, df, dl, ne, r0);
    check("midrst mem cleared", df, 32'h0);

    // Randomized bursts against the model.
    for (int t = 0; t < 80; t++) begin
      int a, l, s, b, sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)      a = $urandom_range(0, 'h7F);
      else if (sel < 8) a = 'h3C0 + $urandom_range(0, 'h3F);
      else              a = $urandom_range(0, 65535);
      if ($urandom_range(0, 9) < 8) a = a & ~3;
      sel = $urandom_range(0, 9);
      b = (sel < 5) ? 1 : (sel < 7) ? 0 : (sel < 9) ? 2 : 3;
      l = (b == 2 && $urandom_range(0, 9) < 8) ? wl[$urandom_range(0, 3)] : $urandom_range(0, 15);
      s = ($urandom_range(0, 9) < 9) ? 2 : $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, s, b, 4'($urandom_range(0, 15)), $urandom, 1'b0, 1'b1, resp);
      else
        do_read(a, l, s, b, 1'b1, df, dl, ne, r0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
